// File: rtl/sdp_fifo_pkg.sv
// Shared helpers for sdp_fifo_ctrl: level port width and wrapping pointer increment.
// Pointers wrap at DEPTH-1, so DEPTH does not have to be a power of two.
package sdp_fifo_pkg;

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sdp_mem.sv
// Simple dual-port RAM: port A writes, port B reads into a registered output (1-cycle latency).
// dob only changes on an enb cycle, so it holds the last read word while enb is low.
module sdp_mem #(
  parameter int unsigned W_DATA = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned W_ADDR = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              ena,
  input  logic              wea,
  input  logic [W_ADDR-1:0] addra,
  input  logic [W_DATA-1:0] dia,
  input  logic              enb,
  input  logic [W_ADDR-1:0] addrb,
  output logic [W_DATA-1:0] dob
);

  logic [W_DATA-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ena && wea) begin
      r_mem[addra] <= dia;
    end
    if (enb) begin
      dob <= r_mem[addrb];
    end
  end

endmodule

// File: rtl/sdp_fifo_ctrl.sv
// FIFO sequencer for an external sdp_mem; push to dout_valid in 2 cycles when empty, 1 word/cycle.
// Reads stall while the head is backpressured; SDP_FIFO_CTRL_LEVEL_EN adds the level output.
module sdp_fifo_ctrl
  import sdp_fifo_pkg::*;
#(
  parameter int unsigned W_DATA = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned W_ADDR = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [W_DATA-1:0] din_data,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [W_ADDR-1:0] mem_addra,
  output logic [W_DATA-1:0] mem_dia,
  output logic              mem_enb,
  output logic [W_ADDR-1:0] mem_addrb,
  input  logic [W_DATA-1:0] mem_dob
`ifdef SDP_FIFO_CTRL_LEVEL_EN
  ,
  output logic [lvl_w(DEPTH)-1:0] level
`endif
);

  localparam logic [W_ADDR:0] L_DEPTH = (W_ADDR + 1)'(DEPTH);

  logic [W_ADDR-1:0] r_wr_ptr;
  logic [W_ADDR-1:0] r_rd_ptr;
  logic [W_ADDR:0]   r_mem_cnt;
  logic              r_dout_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_issue;

  assign din_ready  = !flush && (r_mem_cnt < L_DEPTH);
  assign w_push     = din_valid && din_ready;
  assign w_pop      = r_dout_valid && dout_ready;
  // Refill the output register whenever it is empty or being consumed this cycle.
  assign w_rd_issue = !flush && (r_mem_cnt != '0) && (!r_dout_valid || dout_ready);

  assign mem_ena    = w_push;
  assign mem_wea    = w_push;
  assign mem_addra  = r_wr_ptr;
  assign mem_dia    = din_data;
  assign mem_enb    = w_rd_issue;
  assign mem_addrb  = r_rd_ptr;
  assign dout_data  = mem_dob;
  assign dout_valid = r_dout_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_cnt    <= '0;
      r_dout_valid <= 1'b0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_cnt    <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= W_ADDR'(ptr_inc(32'(r_wr_ptr), DEPTH));
      end
      if (w_rd_issue) begin
        r_rd_ptr <= W_ADDR'(ptr_inc(32'(r_rd_ptr), DEPTH));
      end
      case ({w_push, w_rd_issue})
        2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
        2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      if (w_rd_issue) begin
        r_dout_valid <= 1'b1;
      end else if (w_pop) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

`ifdef SDP_FIFO_CTRL_LEVEL_EN
  assign level = lvl_w(DEPTH)'(r_mem_cnt) + lvl_w(DEPTH)'(r_dout_valid);
`endif

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Bench for sdp_fifo_ctrl paired with sdp_mem: instance a uses DEPTH=4, instance b uses DEPTH=5.
module tb_sdp_fifo_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic        a_flush, a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
  logic        a_mem_ena, a_mem_wea, a_mem_enb;
  logic [15:0] a_din_data, a_dout_data, a_mem_dia, a_mem_dob;
  logic [1:0]  a_mem_addra, a_mem_addrb;
  logic        b_flush, b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
  logic        b_mem_ena, b_mem_wea, b_mem_enb;
  logic [15:0] b_din_data, b_dout_data, b_mem_dia, b_mem_dob;
  logic [2:0]  b_mem_addra, b_mem_addrb;
`ifdef SDP_FIFO_CTRL_LEVEL_EN
  logic [2:0]  a_level, b_level;
`endif

  always #5 clk = ~clk;

  sdp_fifo_ctrl #(.W_DATA(16), .DEPTH(4), .W_ADDR(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .din_data(a_din_data), .din_valid(a_din_valid),
    .din_ready(a_din_ready), .dout_data(a_dout_data), .dout_valid(a_dout_valid),
    .dout_ready(a_dout_ready), .mem_ena(a_mem_ena), .mem_wea(a_mem_wea), .mem_addra(a_mem_addra),
    .mem_dia(a_mem_dia), .mem_enb(a_mem_enb), .mem_addrb(a_mem_addrb), .mem_dob(a_mem_dob)
`ifdef SDP_FIFO_CTRL_LEVEL_EN
    , .level(a_level)
`endif
  );
  sdp_mem #(.W_DATA(16), .DEPTH(4), .W_ADDR(2)) u_a_mem (
    .clk(clk), .ena(a_mem_ena), .wea(a_mem_wea), .addra(a_mem_addra), .dia(a_mem_dia),
    .enb(a_mem_enb), .addrb(a_mem_addrb), .dob(a_mem_dob)
  );

  sdp_fifo_ctrl #(.W_DATA(16), .DEPTH(5), .W_ADDR(3)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .din_data(b_din_data), .din_valid(b_din_valid),
    .din_ready(b_din_ready), .dout_data(b_dout_data), .dout_valid(b_dout_valid),
    .dout_ready(b_dout_ready), .mem_ena(b_mem_ena), .mem_wea(b_mem_wea), .mem_addra(b_mem_addra),
    .mem_dia(b_mem_dia), .mem_enb(b_mem_enb), .mem_addrb(b_mem_addrb), .mem_dob(b_mem_dob)
`ifdef SDP_FIFO_CTRL_LEVEL_EN
    , .level(b_level)
`endif
  );
  sdp_mem #(.W_DATA(16), .DEPTH(5), .W_ADDR(3)) u_b_mem (
    .clk(clk), .ena(b_mem_ena), .wea(b_mem_wea), .addra(b_mem_addra), .dia(b_mem_dia),
    .enb(b_mem_enb), .addrb(b_mem_addrb), .dob(b_mem_dob)
  );

  // Drive one cycle of stimulus on instance b, settled just after the falling edge.
  task automatic set_b(input logic vld, input logic [15:0] dat, input logic rdy, input logic fl);
    @(negedge clk);
    b_din_valid = vld; b_din_data = dat; b_dout_ready = rdy; b_flush = fl;
    #1;
  endtask

  task automatic idle_inputs();
    a_flush = 0; a_din_valid = 0; a_din_data = '0; a_dout_ready = 0;
    b_flush = 0; b_din_valid = 0; b_din_data = '0; b_dout_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; idle_inputs();
    #1;
    vectors++; if (a_dout_valid !== 1'b0) begin miscompares++; $display("FAIL rst_dv_a: got %b want 0", a_dout_valid); end
    vectors++; if (b_dout_valid !== 1'b0) begin miscompares++; $display("FAIL rst_dv_b: got %b want 0", b_dout_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    vectors++; if (a_din_ready !== 1'b1) begin miscompares++; $display("FAIL rst_rdy_a: got %b want 1", a_din_ready); end
    vectors++; if (b_din_ready !== 1'b1) begin miscompares++; $display("FAIL rst_rdy_b: got %b want 1", b_din_ready); end
    vectors++; if (b_mem_enb !== 1'b0) begin miscompares++; $display("FAIL rst_enb_b: got %b want 0", b_mem_enb); end
`ifdef SDP_FIFO_CTRL_LEVEL_EN
    vectors++; if (b_level !== 3'd0) begin miscompares++; $display("FAIL rst_level_b: got %0d want 0", b_level); end
`endif
  endtask

  task automatic test_fill_depth4();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_din_valid = 1; a_din_data = 16'(k + 1); a_dout_ready = 0;
      #1;
      vectors++; if (a_din_ready !== 1'b1) begin miscompares++; $display("FAIL fill_rdy[%0d]: got %b want 1", k, a_din_ready); end
    end
    @(negedge clk);
    a_din_data = 16'd6;
    #1;
    vectors++; if (a_din_ready !== 1'b0) begin miscompares++; $display("FAIL full_rdy: got %b want 0", a_din_ready); end
    vectors++; if (a_dout_valid !== 1'b1) begin miscompares++; $display("FAIL full_dv: got %b want 1", a_dout_valid); end
    vectors++; if (a_dout_data !== 16'd1) begin miscompares++; $display("FAIL full_head: got %0d want 1", a_dout_data); end
`ifdef SDP_FIFO_CTRL_LEVEL_EN
    vectors++; if (a_level !== 3'd5) begin miscompares++; $display("FAIL full_level: got %0d want 5", a_level); end
`endif
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_din_valid = 0; a_dout_ready = 1;
      #1;
      vectors++; if (a_dout_valid !== (k < 5)) begin miscompares++; $display("FAIL drain_dv[%0d]: got %b want %b", k, a_dout_valid, k < 5); end
      if (k < 5) begin
        vectors++; if (a_dout_data !== 16'(k + 1)) begin miscompares++; $display("FAIL drain_dat[%0d]: got %0d want %0d", k, a_dout_data, k + 1); end
      end
    end
    @(negedge clk);
    a_dout_ready = 0;
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 104; c++) begin
      set_b(c < 100, 16'(c), 1'b1, 1'b0);
      vectors++; if (b_din_ready !== 1'b1) begin miscompares++; $display("FAIL stream_rdy[%0d]: got %b want 1", c, b_din_ready); end
      vectors++; if (b_dout_valid !== (c >= 2 && c < 102)) begin miscompares++; $display("FAIL stream_dv[%0d]: got %b want %b", c, b_dout_valid, c >= 2 && c < 102); end
      if (c >= 2 && c < 102) begin
        vectors++; if (b_dout_data !== 16'(c - 2)) begin miscompares++; $display("FAIL stream_dat[%0d]: got %0d want %0d", c, b_dout_data, c - 2); end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] mq[$];
    bit          mhv;
    int          mwp, mrp, sent, got, cyc, mem;
    logic        vld, rdy, e_rdy, e_iss;
    logic [15:0] dat;
    do_reset();
    mq.delete(); mhv = 0; mwp = 0; mrp = 0; sent = 0; got = 0; cyc = 0;
    while (got < 10000 && cyc < 60000) begin
      vld = (sent < 10000) && ($urandom_range(0, 1) == 1);
      dat = 16'($urandom);
      rdy = ($urandom_range(0, 1) == 1);
      set_b(vld, dat, rdy, 1'b0);
      mem   = mq.size() - int'(mhv);
      e_rdy = (mem < 5);
      e_iss = (mem != 0) && (!mhv || rdy);
      vectors++; if (b_din_ready !== e_rdy) begin miscompares++; $display("FAIL rnd_rdy@%0d: got %b want %b", cyc, b_din_ready, e_rdy); end
      vectors++; if (b_dout_valid !== mhv) begin miscompares++; $display("FAIL rnd_dv@%0d: got %b want %b", cyc, b_dout_valid, mhv); end
      vectors++; if (b_mem_enb !== e_iss) begin miscompares++; $display("FAIL rnd_enb@%0d: got %b want %b", cyc, b_mem_enb, e_iss); end
      vectors++; if (b_mem_ena !== (vld && e_rdy)) begin miscompares++; $display("FAIL rnd_ena@%0d: got %b want %b", cyc, b_mem_ena, vld && e_rdy); end
      if (mhv) begin
        vectors++; if (b_dout_data !== mq[0]) begin miscompares++; $display("FAIL rnd_dat@%0d: got %h want %h", cyc, b_dout_data, mq[0]); end
      end
      if (vld && e_rdy) begin
        vectors++; if (b_mem_addra !== 3'(mwp)) begin miscompares++; $display("FAIL rnd_wptr@%0d: got %0d want %0d", cyc, b_mem_addra, mwp); end
      end
      if (e_iss) begin
        vectors++; if (b_mem_addrb !== 3'(mrp)) begin miscompares++; $display("FAIL rnd_rptr@%0d: got %0d want %0d", cyc, b_mem_addrb, mrp); end
      end
`ifdef SDP_FIFO_CTRL_LEVEL_EN
      vectors++; if (b_level !== 3'(mq.size())) begin miscompares++; $display("FAIL rnd_level@%0d: got %0d want %0d", cyc, b_level, mq.size()); end
`endif
      if (mhv && rdy) begin void'(mq.pop_front()); got++; end
      if (vld && e_rdy) begin mq.push_back(dat); mwp = (mwp + 1) % 5; sent++; end
      if (e_iss) mrp = (mrp + 1) % 5;
      if (e_iss) mhv = 1;
      else if (rdy) mhv = 0;
      cyc++;
    end
    vectors++; if (got != 10000) begin miscompares++; $display("FAIL rnd_budget: got %0d words want 10000", got); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 3; k++) set_b(1'b1, 16'(16'hA1 + k), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      set_b(1'b0, 16'h0, 1'b0, 1'b0);
      vectors++; if (b_mem_enb !== 1'b0) begin miscompares++; $display("FAIL bp_enb[%0d]: got %b want 0", k, b_mem_enb); end
      vectors++; if (b_dout_valid !== 1'b1) begin miscompares++; $display("FAIL bp_dv[%0d]: got %b want 1", k, b_dout_valid); end
      vectors++; if (b_dout_data !== 16'hA1) begin miscompares++; $display("FAIL bp_dat[%0d]: got %h want a1", k, b_dout_data); end
`ifdef SDP_FIFO_CTRL_LEVEL_EN
      vectors++; if (b_level !== 3'd3) begin miscompares++; $display("FAIL bp_level[%0d]: got %0d want 3", k, b_level); end
`endif
    end
    for (int k = 0; k < 4; k++) begin
      set_b(1'b0, 16'h0, 1'b1, 1'b0);
      vectors++; if (b_dout_valid !== (k < 3)) begin miscompares++; $display("FAIL bp_drain_dv[%0d]: got %b want %b", k, b_dout_valid, k < 3); end
      if (k < 3) begin
        vectors++; if (b_dout_data !== 16'(16'hA1 + k)) begin miscompares++; $display("FAIL bp_drain_dat[%0d]: got %h want %h", k, b_dout_data, 16'hA1 + k); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) set_b(1'b1, 16'(16'hC0 + k), 1'b0, 1'b0);
    set_b(1'b1, 16'hDEAD, 1'b0, 1'b1);
    vectors++; if (b_din_ready !== 1'b0) begin miscompares++; $display("FAIL fl_rdy: got %b want 0", b_din_ready); end
    vectors++; if (b_mem_ena !== 1'b0) begin miscompares++; $display("FAIL fl_ena: got %b want 0", b_mem_ena); end
    vectors++; if (b_mem_enb !== 1'b0) begin miscompares++; $display("FAIL fl_enb: got %b want 0", b_mem_enb); end
    set_b(1'b0, 16'h0, 1'b1, 1'b0);
    vectors++; if (b_dout_valid !== 1'b0) begin miscompares++; $display("FAIL fl_dv: got %b want 0", b_dout_valid); end
    vectors++; if (b_mem_enb !== 1'b0) begin miscompares++; $display("FAIL fl_empty_enb: got %b want 0", b_mem_enb); end
`ifdef SDP_FIFO_CTRL_LEVEL_EN
    vectors++; if (b_level !== 3'd0) begin miscompares++; $display("FAIL fl_level: got %0d want 0", b_level); end
`endif
    set_b(1'b1, 16'h5A5A, 1'b1, 1'b0);
    vectors++; if (b_mem_addra !== 3'd0) begin miscompares++; $display("FAIL fl_wptr: got %0d want 0", b_mem_addra); end
    set_b(1'b0, 16'h0, 1'b1, 1'b0);
    set_b(1'b0, 16'h0, 1'b1, 1'b0);
    vectors++; if (b_dout_valid !== 1'b1) begin miscompares++; $display("FAIL fl_after_dv: got %b want 1", b_dout_valid); end
    vectors++; if (b_dout_data !== 16'h5A5A) begin miscompares++; $display("FAIL fl_after_dat: got %h want 5a5a", b_dout_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 5; k++) set_b(1'b1, 16'(16'h300 + k), 1'b1, 1'b0);
    vectors++; if (b_dout_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre_dv: got %b want 1", b_dout_valid); end
    #2;
    rst_n = 0;
    #1;
    vectors++; if (b_dout_valid !== 1'b0) begin miscompares++; $display("FAIL ar_dv_now: got %b want 0", b_dout_valid); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    #1;
    vectors++; if (b_mem_enb !== 1'b0) begin miscompares++; $display("FAIL ar_enb: got %b want 0", b_mem_enb); end
    vectors++; if (b_din_ready !== 1'b1) begin miscompares++; $display("FAIL ar_rdy: got %b want 1", b_din_ready); end
    set_b(1'b1, 16'h7777, 1'b1, 1'b0);
    vectors++; if (b_mem_addra !== 3'd0) begin miscompares++; $display("FAIL ar_wptr: got %0d want 0", b_mem_addra); end
    set_b(1'b0, 16'h0, 1'b1, 1'b0);
    vectors++; if (b_dout_valid !== 1'b0) begin miscompares++; $display("FAIL ar_lat_dv: got %b want 0", b_dout_valid); end
    set_b(1'b0, 16'h0, 1'b1, 1'b0);
    vectors++; if (b_dout_valid !== 1'b1) begin miscompares++; $display("FAIL ar_new_dv: got %b want 1", b_dout_valid); end
    vectors++; if (b_dout_data !== 16'h7777) begin miscompares++; $display("FAIL ar_new_dat: got %h want 7777", b_dout_data); end
  endtask

  initial begin
    clk = 0; rst_n = 0; vectors = 0; miscompares = 0;
    idle_inputs();
    test_reset();
    test_fill_depth4();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
